// File: rtl/seven_segment_pkg.sv
// Shared glyphs, digit type and wrap limit for the seven-segment counter.
// SEVEN_SEGMENT_HEX_EN selects a 0-F counter; otherwise the counter runs 0-9.
package seven_segment_pkg;

    typedef logic [3:0] digit_t;

    // Glyphs on bits g..a, active-high, common-cathode
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

`ifdef SEVEN_SEGMENT_HEX_EN
    localparam digit_t DIGIT_MAX = 4'hF;
`else
    localparam digit_t DIGIT_MAX = 4'd9;
`endif

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational 4-bit digit to 7-segment glyph decode.
// SEVEN_SEGMENT_HEX_EN adds the A-F glyphs; otherwise codes 10-15 blank the digit.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'h0: segments = SEG_0;
            4'h1: segments = SEG_1;
            4'h2: segments = SEG_2;
            4'h3: segments = SEG_3;
            4'h4: segments = SEG_4;
            4'h5: segments = SEG_5;
            4'h6: segments = SEG_6;
            4'h7: segments = SEG_7;
            4'h8: segments = SEG_8;
            4'h9: segments = SEG_9;
`ifdef SEVEN_SEGMENT_HEX_EN
            4'hA: segments = SEG_A;
            4'hB: segments = SEG_B;
            4'hC: segments = SEG_C;
            4'hD: segments = SEG_D;
            4'hE: segments = SEG_E;
            4'hF: segments = SEG_F;
`endif
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_counter.sv
// Prescaled digit counter driving one seven-segment digit on the Caravel user pads.
// Define SEVEN_SEGMENT_HEX_EN for a 0-F counter; the default build counts 0-9.
module seven_segment_counter
    import seven_segment_pkg::*;
#(
    parameter int                   COMPARE_W       = 24,
    parameter logic [COMPARE_W-1:0] DEFAULT_COMPARE = COMPARE_W'(10_000_000)
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic [COMPARE_W-1:0] cfg_wdata,
    output logic [3:0]           digit,
    output logic [6:0]           segments,
    output logic [6:0]           segments_oeb
);

    localparam logic [COMPARE_W-1:0] ONE = COMPARE_W'(1);

    logic [COMPARE_W-1:0] presc_q, presc_d;
    logic [COMPARE_W-1:0] compare_q, compare_d;
    digit_t               digit_q, digit_d;
    logic                 tick;

    // A config write restarts the period and swallows any tick due in the same cycle
    always_comb begin
        presc_d   = presc_q;
        compare_d = compare_q;
        digit_d   = digit_q;
        tick      = 1'b0;
        if (cfg_we) begin
            compare_d = cfg_wdata;
            presc_d   = '0;
        end else if (enable && (compare_q != '0)) begin
            if (presc_q == (compare_q - ONE)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + ONE;
            end
        end
        if (tick) begin
            digit_d = (digit_q == DIGIT_MAX) ? digit_t'(0) : digit_q + digit_t'(1);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            presc_q   <= '0;
            compare_q <= DEFAULT_COMPARE;
            digit_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            compare_q <= compare_d;
            digit_q   <= digit_d;
        end
    end

    seven_segment_decoder u_decoder (
        .digit    (digit_q),
        .segments (segments)
    );

    assign digit        = digit_q;
    assign segments_oeb = '0;

endmodule

// File: tb/tb_seven_segment_counter.sv
// Directed, table-driven bench for seven_segment_counter plus hand-written corner sequences.
// Honours SEVEN_SEGMENT_HEX_EN to pick the expected wrap point and glyph set.
module tb_seven_segment_counter;

    localparam int COMPARE_W = 24;
`ifdef SEVEN_SEGMENT_HEX_EN
    localparam int WRAP = 16;
`else
    localparam int WRAP = 10;
`endif

    logic                 clock = 1'b0;
    logic                 resetb;
    logic                 enable;
    logic                 cfg_we;
    logic [COMPARE_W-1:0] cfg_wdata;
    logic [3:0]           digit;
    logic [6:0]           segments;
    logic [6:0]           segments_oeb;

    logic [3:0]           dec_in;
    logic [6:0]           dec_out;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic                 we;
        logic [COMPARE_W-1:0] wdata;
        logic                 en;
        logic [3:0]           expDigit;
        logic [6:0]           expSeg;
    } vec_t;

    vec_t vecs[$];

    seven_segment_counter #(
        .COMPARE_W       (COMPARE_W),
        .DEFAULT_COMPARE (24'd10_000_000)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_wdata    (cfg_wdata),
        .digit        (digit),
        .segments     (segments),
        .segments_oeb (segments_oeb)
    );

    seven_segment_decoder u_dec (
        .digit    (dec_in),
        .segments (dec_out)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
`ifdef SEVEN_SEGMENT_HEX_EN
            10: return 7'h77;
            11: return 7'h7C;
            12: return 7'h39;
            13: return 7'h5E;
            14: return 7'h79;
            15: return 7'h71;
`endif
            default: return 7'h00;
        endcase
    endfunction

    task automatic addRow(input logic we, input int wdata, input logic en, input int d);
        vec_t v;
        v.we       = we;
        v.wdata    = wdata[COMPARE_W-1:0];
        v.en       = en;
        v.expDigit = d[3:0];
        v.expSeg   = glyph(d);
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic we, input int wdata, input logic en);
        cfg_we    = we;
        cfg_wdata = wdata[COMPARE_W-1:0];
        enable    = en;
        @(posedge clock);
        #1;
        cfg_we    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lastD;
        int cur;
        int tickAt;
        int changes;

        resetb    = 1'b0;
        enable    = 1'b0;
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        dec_in    = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_digit", 32'(digit), 32'h0);
        checkOutput("reset_segments", 32'(segments), 32'h3F);
        checkOutput("reset_oeb", 32'(segments_oeb), 32'h0);
        @(negedge clock);
        resetb = 1'b1;

        for (int i = 0; i < 16; i++) begin
            dec_in = i[3:0];
            #1;
            checkOutput($sformatf("decoder_%0d", i), 32'(dec_out), 32'(glyph(i)));
        end

        // compare=4: one tick every four enabled edges
        addRow(1'b1, 4, 1'b1, 0);
        addRow(1'b0, 0, 1'b1, 0);
        addRow(1'b0, 0, 1'b1, 0);
        addRow(1'b0, 0, 1'b1, 0);
        addRow(1'b0, 0, 1'b1, 1);
        addRow(1'b0, 0, 1'b1, 1);
        addRow(1'b0, 0, 1'b1, 1);
        addRow(1'b0, 0, 1'b1, 1);
        addRow(1'b0, 0, 1'b1, 2);
        // two enabled edges, seven disabled, then the held prescaler finishes the period
        addRow(1'b0, 0, 1'b1, 2);
        addRow(1'b0, 0, 1'b1, 2);
        for (int k = 0; k < 7; k++) addRow(1'b0, 0, 1'b0, 2);
        addRow(1'b0, 0, 1'b1, 2);
        addRow(1'b0, 0, 1'b1, 3);
        // compare=1: a tick on every enabled edge, crossing the wrap point
        addRow(1'b1, 1, 1'b1, 3);
        for (int k = 1; k <= 16; k++) addRow(1'b0, 0, 1'b1, (3 + k) % WRAP);
        lastD = 19 % WRAP;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, int'(vecs[i].wdata), vecs[i].en);
            checkOutput($sformatf("vec%0d_digit", i), 32'(digit), 32'(vecs[i].expDigit));
            checkOutput($sformatf("vec%0d_segments", i), 32'(segments), 32'(vecs[i].expSeg));
        end

        // cfg write lands on the tick cycle of a compare=3 period
        cur = lastD;
        applyStimulus(1'b1, 3, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b1, 5, 1'b1);
        checkOutput("collide_no_advance", 32'(digit), 32'(cur));
        tickAt = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 0, 1'b1);
            if (digit !== cur[3:0]) begin
                tickAt = k;
                break;
            end
        end
        checkOutput("tick_after_write_cycles", 32'(tickAt), 32'd5);
        cur = (cur + 1) % WRAP;
        checkOutput("tick_after_write_digit", 32'(digit), 32'(cur));

        // compare=0 halts counting
        applyStimulus(1'b1, 0, 1'b1);
        changes = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, 0, 1'b1);
            if (digit !== cur[3:0]) changes++;
        end
        checkOutput("halt_changes", 32'(changes), 32'd0);
        checkOutput("halt_digit", 32'(digit), 32'(cur));

        // mid-count reset with a tick pending on the next edge
        applyStimulus(1'b1, 2, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1);
        cur = (cur + 1) % WRAP;
        checkOutput("pre_reset_digit", 32'(digit), 32'(cur));
        applyStimulus(1'b0, 0, 1'b1);
        #2;
        resetb = 1'b0;
        #1;
        checkOutput("async_reset_digit", 32'(digit), 32'h0);
        checkOutput("async_reset_segments", 32'(segments), 32'h3F);
        @(posedge clock);
        #1;
        checkOutput("reset_pending_tick_dropped", 32'(digit), 32'h0);
        @(negedge clock);
        resetb = 1'b1;
        changes = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 0, 1'b1);
            if (digit !== 4'h0) changes++;
        end
        checkOutput("default_compare_restored", 32'(changes), 32'd0);
        checkOutput("post_reset_oeb", 32'(segments_oeb), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
